// File: rtl/sc_defines_pkg.sv
// Shared definitions for the SimpleCore multi-cycle ALU: word size, op codes,
// flag bit positions and controller state encoding.
package sc_defines;

  localparam int WORD_SIZE = 32;

  localparam logic [3:0] SC_ALU_ADD   = 4'd0;
  localparam logic [3:0] SC_ALU_SUB   = 4'd1;
  localparam logic [3:0] SC_ALU_AND   = 4'd2;
  localparam logic [3:0] SC_ALU_OR    = 4'd3;
  localparam logic [3:0] SC_ALU_XOR   = 4'd4;
  localparam logic [3:0] SC_ALU_SLL   = 4'd5;
  localparam logic [3:0] SC_ALU_SRL   = 4'd6;
  localparam logic [3:0] SC_ALU_SRA   = 4'd7;
  localparam logic [3:0] SC_ALU_SLT   = 4'd8;
  localparam logic [3:0] SC_ALU_SLTU  = 4'd9;
  localparam logic [3:0] SC_ALU_MUL   = 4'd10;
  localparam logic [3:0] SC_ALU_MULHU = 4'd11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == SC_ALU_MUL) || (op == SC_ALU_MULHU);
  endfunction

endpackage

// File: rtl/sc_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle for
// WIDTH cycles. done stays high until the product is taken.
module sc_mul_iter
  import sc_defines::*;
#(
  parameter int WIDTH = WORD_SIZE,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               take,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;
  logic [WIDTH:0]     partial_next;

  // Low half starts as the multiplier; each step adds into the high half and
  // shifts right, so the consumed multiplier bit is always acc_reg[0].
  assign partial_next = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                      + {1'b0, (acc_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
  assign done    = busy_reg && (cnt_reg == LAST_CNT);
  assign product = acc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else if (start) begin
      acc_reg   <= {{WIDTH{1'b0}}, b};
      mcand_reg <= a;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else if (done) begin
      if (take) busy_reg <= 1'b0;
    end else if (busy_reg) begin
      acc_reg <= {partial_next, acc_reg[WIDTH-1:1]};
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/sc_alu_mc.sv
// Multi-cycle ALU top: operand register, combinational datapath and flags,
// controller FSM and the shared result register with valid/ready handshake.
module sc_alu_mc
  import sc_defines::*;
#(
  parameter int WIDTH = WORD_SIZE,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_op_in,
  input  logic [WIDTH-1:0] alu_a_in,
  input  logic [WIDTH-1:0] alu_b_in,
  input  logic             alu_valid_in,
  output logic             alu_ready_out,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       alu_flags_out,
  output logic             alu_valid_out,
  input  logic             alu_ready_in
);

  alu_state_e         state_reg;
  logic               s1_valid_reg;
  logic [3:0]         s1_op_reg;
  logic [WIDTH-1:0]   s1_a_reg;
  logic [WIDTH-1:0]   s1_b_reg;
  logic [WIDTH-1:0]   out_reg;
  logic [3:0]         flags_reg;
  logic               valid_reg;
  logic               mul_hi_reg;

  logic               adv;
  logic               accept;
  logic               accept_mul;
  logic               mul_done;
  logic               mul_take;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_result;
  logic [3:0]         mul_flags;

  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   res_next;
  logic               carry_next;
  logic               ovf_next;
  logic [3:0]         flags_next;

  // The output register may advance whenever it is empty or being consumed.
  assign adv           = !valid_reg || alu_ready_in;
  assign alu_ready_out = (state_reg == ST_IDLE) && adv;
  assign accept        = alu_valid_in && alu_ready_out;
  assign accept_mul    = accept && is_mul_op(alu_op_in);
  assign mul_take      = (state_reg == ST_MULT) && mul_done && adv;

  assign alu_out       = out_reg;
  assign alu_flags_out = flags_reg;
  assign alu_valid_out = valid_reg;

  sc_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_mul),
    .take    (mul_take),
    .a       (alu_a_in),
    .b       (alu_b_in),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_result = mul_hi_reg ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_result[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_result == '0);
  end

  assign shamt    = s1_b_reg[SHW-1:0];
  assign add_full = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
  assign sub_full = {1'b0, s1_a_reg} + {1'b0, ~s1_b_reg} + (WIDTH+1)'(1);

  always_comb begin
    res_next   = s1_a_reg;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (s1_op_reg)
      SC_ALU_ADD: begin
        res_next   = add_full[WIDTH-1:0];
        carry_next = add_full[WIDTH];
        ovf_next   = (s1_a_reg[WIDTH-1] == s1_b_reg[WIDTH-1])
                  && (add_full[WIDTH-1] != s1_a_reg[WIDTH-1]);
      end
      SC_ALU_SUB: begin
        res_next   = sub_full[WIDTH-1:0];
        carry_next = sub_full[WIDTH];
        ovf_next   = (s1_a_reg[WIDTH-1] != s1_b_reg[WIDTH-1])
                  && (sub_full[WIDTH-1] != s1_a_reg[WIDTH-1]);
      end
      SC_ALU_AND:  res_next = s1_a_reg & s1_b_reg;
      SC_ALU_OR:   res_next = s1_a_reg | s1_b_reg;
      SC_ALU_XOR:  res_next = s1_a_reg ^ s1_b_reg;
      SC_ALU_SLL:  res_next = s1_a_reg << shamt;
      SC_ALU_SRL:  res_next = s1_a_reg >> shamt;
      SC_ALU_SRA:  res_next = $unsigned($signed(s1_a_reg) >>> shamt);
      SC_ALU_SLT:  res_next = {{(WIDTH-1){1'b0}}, ($signed(s1_a_reg) < $signed(s1_b_reg))};
      SC_ALU_SLTU: res_next = {{(WIDTH-1){1'b0}}, (s1_a_reg < s1_b_reg)};
      default:     res_next = s1_a_reg;
    endcase
  end

  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_N] = res_next[WIDTH-1];
    flags_next[FLAG_Z] = (res_next == '0);
    flags_next[FLAG_C] = carry_next;
    flags_next[FLAG_V] = ovf_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= '0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      out_reg      <= '0;
      flags_reg    <= '0;
      valid_reg    <= 1'b0;
      mul_hi_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (adv) begin
            valid_reg    <= s1_valid_reg;
            s1_valid_reg <= accept && !accept_mul;
            if (s1_valid_reg) begin
              out_reg   <= res_next;
              flags_reg <= flags_next;
            end
            if (accept && !accept_mul) begin
              s1_op_reg <= alu_op_in;
              s1_a_reg  <= alu_a_in;
              s1_b_reg  <= alu_b_in;
            end
            if (accept_mul) begin
              state_reg  <= ST_MULT;
              mul_hi_reg <= (alu_op_in == SC_ALU_MULHU);
            end
          end
        end
        ST_MULT: begin
          // An older single-cycle result may still be waiting to be consumed.
          if (mul_take) begin
            out_reg   <= mul_result;
            flags_reg <= mul_flags;
            valid_reg <= 1'b1;
            state_reg <= ST_DONE;
          end else if (alu_ready_in) begin
            valid_reg <= 1'b0;
          end
        end
        ST_DONE: begin
          if (alu_ready_in) begin
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_alu_mc.sv
// Self-checking bench for sc_alu_mc: directed literal cases plus randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_sc_alu_mc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    alu_op_in = '0;
  logic [W-1:0]  alu_a_in = '0;
  logic [W-1:0]  alu_b_in = '0;
  logic          alu_valid_in = 1'b0;
  logic          alu_ready_out;
  logic [W-1:0]  alu_out;
  logic [3:0]    alu_flags_out;
  logic          alu_valid_out;
  logic          alu_ready_in = 1'b1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sc_alu_mc #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_op_in     (alu_op_in),
    .alu_a_in      (alu_a_in),
    .alu_b_in      (alu_b_in),
    .alu_valid_in  (alu_valid_in),
    .alu_ready_out (alu_ready_out),
    .alu_out       (alu_out),
    .alu_flags_out (alu_flags_out),
    .alu_valid_out (alu_valid_out),
    .alu_ready_in  (alu_ready_in)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from the operation definitions; returns {flags, result}.
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sr;
    logic [63:0] p;
    logic [31:0] r;
    bit c, v;
    int amt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    amt = int'(b % 32);
    c = 0; v = 0; r = a; sr = 0;
    case (op)
      4'd0: begin r = a + b; c = (longint'(a) + longint'(b)) > 64'sd4294967295;
                  sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      4'd1: begin r = a - b; c = (a >= b);
                  sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << amt;
      4'd6: r = a >> amt;
      4'd7: r = 32'(sa >>> amt);
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin p = 64'(a) * 64'(b); r = p[31:0]; end
      4'd11: begin p = 64'(a) * 64'(b); r = p[63:32]; end
      default: r = a;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  typedef struct {
    logic [31:0] out;
    logic [3:0]  flags;
    int          vis;
    bit          is_mul;
  } exp_t;

  exp_t q[$];

  // Compare process and model update: results leave in order; each becomes
  // visible at its nominal latency or once everything ahead has been consumed.
  initial begin
    bit ev, er, mul_pend;
    logic [35:0] rr;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      ev = (q.size() > 0) && (cyc >= q[0].vis);
      mul_pend = 0;
      foreach (q[i]) if (q[i].is_mul) mul_pend = 1;
      er = !mul_pend && (!ev || alu_ready_in);
      if (!rst) begin
        chk("valid_out", 64'(alu_valid_out), 64'(ev));
        chk("ready_out", 64'(alu_ready_out), 64'(er));
        if (ev) begin
          chk("out", 64'(alu_out), 64'(q[0].out));
          chk("flags", 64'(alu_flags_out), 64'(q[0].flags));
        end
      end
      if (rst) begin
        q.delete();
      end else begin
        if (ev && alu_ready_in) begin
          $display("[TB] cyc %0d result 0x%08h flags %b", cyc, q[0].out, q[0].flags);
          void'(q.pop_front());
        end
        if (alu_valid_in && er) begin
          rr = ref_alu(alu_op_in, alu_a_in, alu_b_in);
          e.out = rr[31:0];
          e.flags = rr[35:32];
          e.is_mul = (alu_op_in == 4'd10) || (alu_op_in == 4'd11);
          e.vis = cyc + 1 + (e.is_mul ? W + 1 : 1);
          q.push_back(e);
        end
      end
      cyc++;
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_out, input logic [3:0] exp_flags);
    bit got, seen, is_mul;
    int acc_cyc;
    is_mul = (op == 4'd10) || (op == 4'd11);
    @(negedge clk);
    alu_op_in = op; alu_a_in = a; alu_b_in = b;
    alu_valid_in = 1'b1; alu_ready_in = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      #1 got = alu_ready_out;
      @(negedge clk);
    end
    chk({name, "_accepted"}, 64'(got), 64'd1);
    acc_cyc = cyc;
    alu_valid_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1 seen = alu_valid_out;
      if (!seen) begin
        if (is_mul) chk({name, "_ready_low"}, 64'(alu_ready_out), 64'd0);
        @(negedge clk);
      end
    end
    chk({name, "_latency"}, 64'(cyc - acc_cyc), 64'(is_mul ? W + 1 : 1));
    chk({name, "_out"}, 64'(alu_out), 64'(exp_out));
    chk({name, "_flags"}, 64'(alu_flags_out), 64'(exp_flags));
    $display("[TB] %s op=%0d a=0x%08h b=0x%08h out=0x%08h flags=%b", name, op, a, b, alu_out, alu_flags_out);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit got, hold;
    int accepted;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", 64'(alu_valid_out), 64'd0);
    chk("reset_out", 64'(alu_out), 64'd0);
    chk("reset_flags", 64'(alu_flags_out), 64'd0);
    chk("reset_ready", 64'(alu_ready_out), 64'd1);

    run_op("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1001);
    run_op("sub_eq",   4'd1,  32'd5,         32'd5,         32'd0,         4'b0110);
    run_op("sub_neg",  4'd1,  32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000);
    run_op("sra",      4'd7,  32'h8000_0000, 32'h21,        32'hC000_0000, 4'b1000);
    run_op("srl",      4'd6,  32'h8000_0000, 32'h21,        32'h4000_0000, 4'b0000);
    run_op("sll_zero", 4'd5,  32'h0000_00A5, 32'h100,       32'h0000_00A5, 4'b0000);
    run_op("slt_min",  4'd8,  32'h8000_0000, 32'd0,         32'd1,         4'b0000);
    run_op("mul",      4'd10, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 4'b1000);
    run_op("mulhu",    4'd11, 32'hFFFF_FFFF, 32'd2,         32'd1,         4'b0000);
    run_op("mul_b0",   4'd10, 32'd12345,     32'd0,         32'd0,         4'b0100);

    // Back-pressure: result held for 5 cycles, then consume and accept together.
    @(negedge clk);
    alu_op_in = 4'd0; alu_a_in = 32'd1; alu_b_in = 32'd2;
    alu_valid_in = 1'b1; alu_ready_in = 1'b0;
    #1 chk("bp_accept", 64'(alu_ready_out), 64'd1);
    @(negedge clk);
    alu_valid_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid_held", 64'(alu_valid_out), 64'd1);
      chk("bp_out_held", 64'(alu_out), 64'd3);
      chk("bp_ready_low", 64'(alu_ready_out), 64'd0);
      @(negedge clk);
    end
    alu_op_in = 4'd0; alu_a_in = 32'd10; alu_b_in = 32'd20;
    alu_valid_in = 1'b1; alu_ready_in = 1'b1;
    #1 chk("bp_release_ready", 64'(alu_ready_out), 64'd1);
    @(negedge clk);
    alu_valid_in = 1'b0;
    #1 chk("bp_gap_valid", 64'(alu_valid_out), 64'd0);
    @(negedge clk);
    #1;
    chk("bp_next_valid", 64'(alu_valid_out), 64'd1);
    chk("bp_next_out", 64'(alu_out), 64'd30);
    $display("[TB] backpressure add 10+20 out=0x%08h", alu_out);

    // Reset ten cycles into a multiply discards it.
    @(negedge clk);
    alu_op_in = 4'd10; alu_a_in = 32'd7; alu_b_in = 32'd9;
    alu_valid_in = 1'b1; alu_ready_in = 1'b1;
    #1 chk("rstmul_accept", 64'(alu_ready_out), 64'd1);
    @(negedge clk);
    alu_valid_in = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmul_valid", 64'(alu_valid_out), 64'd0);
    chk("rstmul_ready", 64'(alu_ready_out), 64'd1);
    $display("[TB] reset during mul: valid=%0b ready=%0b", alu_valid_out, alu_ready_out);
    run_op("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 4'b0000);

    // Randomized traffic with random consumer stalls; the producer holds
    // its request until it is accepted.
    accepted = 0;
    hold = 0;
    for (int i = 0; i < 20000 && accepted < 250; i++) begin
      @(negedge clk);
      alu_ready_in = ($urandom_range(0, 9) < 7);
      if (!hold) begin
        if ($urandom_range(0, 9) < 6) begin
          alu_op_in = 4'($urandom_range(0, 15));
          if ((alu_op_in == 4'd10 || alu_op_in == 4'd11) && $urandom_range(0, 3) != 0)
            alu_op_in = 4'($urandom_range(0, 9));
          alu_a_in = pick_val();
          alu_b_in = pick_val();
          alu_valid_in = 1'b1;
        end else begin
          alu_valid_in = 1'b0;
        end
      end
      #1 got = alu_valid_in && alu_ready_out;
      if (got) begin
        accepted++;
        hold = 0;
      end else begin
        hold = alu_valid_in;
      end
    end
    chk("random_ops_accepted", 64'(accepted >= 250), 64'd1);
    @(negedge clk);
    alu_valid_in = 1'b0;
    alu_ready_in = 1'b1;
    repeat (2 * W + 8) @(negedge clk);
    #3;
    chk("drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
